pulse_sequencer: RTL and testbench
==================================

# pulse_sequencer

Symbol sequencer that sits directly upstream of the one-shot countdown timer in the pulse transmitter. It buffers (level, duration) symbols in a small FIFO. It drives the transmit line to each symbol's level, fires the timer's trigger with the symbol duration, and advances on the timer's completion pulse. When the FIFO drains it returns the line to the idle level and signals done.

## Interface
- `TIMER_WIDTH`, 8, width of symbol duration; matches the timer.
- `DEPTH`, 8, FIFO entries; power of 2, ≥2.
- `clk` input 1: single clock, all logic on rising edge.
- `sys_rst_n` input 1: reset, asynchronous, active-low.
- `wr_valid` input 1: symbol write request.
- `wr_level` input 1: line level for the symbol.
- `wr_duration` input TIMER_WIDTH: symbol duration in timer counts.
- `wr_ready` output 1: FIFO can accept a symbol.
- `start` input 1: begin transmission (level-sampled, acted on in IDLE only).
- `abort` input 1: stop immediately and flush FIFO.
- `idle_level` input 1: line level when not transmitting.
- `tim_done` input 1: one-cycle completion pulse from the timer.
- `tim_trig` output 1: timer trigger, one-cycle high pulse.
- `tim_duration` output TIMER_WIDTH: duration presented to the timer, held stable until the next ARM.
- `tx_out` output 1: transmit line.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `fifo_count` output $clog2(DEPTH+1): entries currently stored.

## Operation
- **FIFO**
  - Circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap naturally.
  - Count register is 0..DEPTH.
  - Write occurs when `wr_valid && wr_ready`.
  - `wr_ready = (fifo_count < DEPTH) && !abort`, based on the registered count only. There is no same-cycle pop bypass, so a full FIFO refuses writes even in a pop cycle.
  - A simultaneous push and pop leaves the count unchanged.
- **States:** IDLE, LOAD, ARM, WAIT.
- **IDLE**
  - `tx_out` is `idle_level`, combinational pass-through.
  - If `start` and `fifo_count != 0`, go to LOAD.
  - `start` with an empty FIFO is ignored: no `done` pulse, no state change.
- **LOAD**
  - Pop the head into the symbol register.
  - If the popped duration is 0, the symbol is skipped with no trigger:
    - if `fifo_count > 1`, go to LOAD;
    - otherwise go to IDLE and pulse `done`.
  - If the duration is non-zero, go to ARM.
- **ARM** (one cycle)
  - `tx_out` = symbol level.
  - `tim_trig` = 1.
  - `tim_duration` = symbol duration.
  - Go to WAIT.
- **WAIT**
  - `tim_trig` = 0.
  - `tx_out` holds the symbol level.
  - On `tim_done`:
    - if `fifo_count != 0`, go to LOAD;
    - otherwise go to IDLE and pulse `done`.
- **`tim_done` outside WAIT** is ignored.
- **Writes during transmission** are allowed and extend the sequence. The empty check uses the registered count, so a write landing in the same cycle as the final `tim_done` is not seen: the block goes to IDLE, and the entry remains for the next `start`.
- **`abort`**
  - Has priority over everything, in any state.
  - Next state is IDLE, the FIFO is flushed (pointers and count to 0), and `tim_trig` is cleared.
  - No `done` pulse.
  - Any write in the same cycle is dropped.
- **Reset**
  - Asynchronous; takes effect mid-operation immediately.
  - State returns to IDLE, the FIFO empties, and the outputs take the values below.

## Timing
- **Reset values**
  - `tim_trig` = 0, `tim_duration` = 0, `done` = 0, `busy` = 0, `fifo_count` = 0.
  - `wr_ready` = 1.
  - `tx_out` = `idle_level`.
- **Registered outputs:** `tim_trig`, `tim_duration`, `done`, and `tx_out` in the non-IDLE states.
- **Start latency:** with `start` sampled at edge N:
  - LOAD is in cycle N+1;
  - `tim_trig` is high and `tx_out` takes the symbol level in cycle N+2;
  - `tim_trig` is low from N+3.
- **Inter-symbol overhead:** `tim_done` in cycle M gives LOAD in M+1 and a new `tim_trig` in M+2. The line changes level exactly when `tim_trig` rises.
- **`tim_trig`** is never high on two consecutive cycles, so the timer's rising-edge trigger always re-arms.
- **Completion:** `done` is high in the first IDLE cycle after the last symbol, and `tx_out` returns to `idle_level` in that same cycle.
- **`fifo_count`** updates one cycle after the write or pop.

## Test plan
- **Single symbol:** reset, write (level 1, duration 5), `idle_level` 0, `start`.
  - Response: `tim_trig` is a single pulse 2 cycles after `start`, with `tim_duration` = 5 and `tx_out` = 1.
  - Inject `tim_done` 6 cycles later: `tx_out` = 0, `done` pulses once, `busy` falls.
- **Three symbols:** (1,3), (0,4), (1,2).
  - Response: `tx_out` follows 1/0/1; exactly 3 `tim_trig` pulses, each 2 cycles after the previous `tim_done`; `done` after the third.
- **Full/wrap:** write 8 symbols.
  - After the 8th, `wr_ready` = 0 and a 9th write is ignored.
  - Pop 3 via transmission, write 3 more: order preserved across the pointer wrap, `fifo_count` correct.
- **Zero duration:** symbols (1,0), (0,7).
  - Response: no trigger for the first; the only `tim_trig` carries duration 7 with `tx_out` = 0.
  - A FIFO holding only (1,0) gives `done` with no trigger.
- **Abort:** in WAIT with 4 symbols queued, assert `abort` with a simultaneous write.
  - Response: IDLE next cycle, `fifo_count` = 0, no `done`.
  - A late `tim_done` is ignored.
- **Async reset mid-WAIT:** drop `sys_rst_n` between clock edges.
  - Response: outputs reach reset values before the next edge.
  - Writes are accepted after reset release.

Source files
------------

// File: rtl/pulse_sequencer.sv
// Symbol sequencer feeding a one-shot countdown timer: buffers (level, duration) symbols in a FIFO
// and plays them out on tx_out, one timer trigger per non-zero symbol.
module pulse_sequencer #(
    parameter int unsigned TIMER_WIDTH = 8,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                         clk,
    input  logic                         sys_rst_n,
    input  logic                         wr_valid,
    input  logic                         wr_level,
    input  logic [TIMER_WIDTH-1:0]       wr_duration,
    output logic                         wr_ready,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         idle_level,
    input  logic                         tim_done,
    output logic                         tim_trig,
    output logic [TIMER_WIDTH-1:0]       tim_duration,
    output logic                         tx_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StArm, StWait} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   mem_level [DEPTH];
    logic [TIMER_WIDTH-1:0] mem_dur   [DEPTH];

    logic                   trig_q, trig_d;
    logic [TIMER_WIDTH-1:0] dur_q, dur_d;
    logic                   done_q, done_d;
    logic                   tx_q, tx_d;
    logic                   push, pop;
    logic                   head_level;
    logic [TIMER_WIDTH-1:0] head_dur;

    assign wr_ready   = (count_q < CW'(DEPTH)) && !abort;
    assign push       = wr_valid && wr_ready;
    assign head_level = mem_level[rd_ptr_q];
    assign head_dur   = mem_dur[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_level[wr_ptr_q] <= wr_level;
            mem_dur[wr_ptr_q]   <= wr_duration;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        tx_d    = tx_q;
        dur_d   = dur_q;
        case (state_q)
            StIdle: begin
                if (start && count_q != '0) begin
                    state_d = StLoad;
                    // Line keeps the idle level until the first trigger fires.
                    tx_d    = idle_level;
                end
            end
            StLoad: begin
                pop = 1'b1;
                if (head_dur == '0) begin
                    if (count_q > CW'(1)) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = StArm;
                    trig_d  = 1'b1;
                    dur_d   = head_dur;
                    tx_d    = head_level;
                end
            end
            StArm: begin
                state_d = StWait;
            end
            StWait: begin
                if (tim_done) begin
                    if (count_q != '0) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            pop     = 1'b0;
            trig_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
            dur_q   <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    assign tim_trig     = trig_q;
    assign tim_duration = dur_q;
    assign done         = done_q;
    assign busy         = (state_q != StIdle);
    assign tx_out       = (state_q == StIdle) ? idle_level : tx_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: the bench plays the timer by hand and checks every
// output against hand-computed values.
module tb_pulse_sequencer;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_level = 1'b0;
    logic [7:0] wr_duration = '0;
    logic       wr_ready;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       idle_level = 1'b0;
    logic       tim_done = 1'b0;
    logic       tim_trig;
    logic [7:0] tim_duration;
    logic       tx_out;
    logic       busy;
    logic       done;
    logic [3:0] fifo_count;

    int errors = 0;
    int checks = 0;

    pulse_sequencer #(.TIMER_WIDTH(8), .DEPTH(8)) dut (
        .clk         (clk),
        .sys_rst_n   (sys_rst_n),
        .wr_valid    (wr_valid),
        .wr_level    (wr_level),
        .wr_duration (wr_duration),
        .wr_ready    (wr_ready),
        .start       (start),
        .abort       (abort),
        .idle_level  (idle_level),
        .tim_done    (tim_done),
        .tim_trig    (tim_trig),
        .tim_duration(tim_duration),
        .tx_out      (tx_out),
        .busy        (busy),
        .done        (done),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic lvl, input logic [7:0] dur);
        wr_valid    = 1'b1;
        wr_level    = lvl;
        wr_duration = dur;
        step();
        wr_valid    = 1'b0;
    endtask

    // Entered in a LOAD cycle; leaves one cycle after the injected tim_done.
    task automatic do_symbol(input string tag, input logic lvl, input logic [7:0] dur);
        chk({tag, "_load_trig"}, 32'(tim_trig), 32'd0);
        step();
        chk({tag, "_arm_trig"}, 32'(tim_trig), 32'd1);
        chk({tag, "_arm_dur"}, 32'(tim_duration), 32'(dur));
        chk({tag, "_arm_tx"}, 32'(tx_out), 32'(lvl));
        step();
        chk({tag, "_wait_trig"}, 32'(tim_trig), 32'd0);
        tim_done = 1'b1;
        step();
        tim_done = 1'b0;
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_trig", 32'(tim_trig), 32'd0);
        chk("rst_dur", 32'(tim_duration), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_tx0", 32'(tx_out), 32'd0);
        idle_level = 1'b1;
        #1;
        chk("rst_tx1", 32'(tx_out), 32'd1);
        idle_level = 1'b0;
        @(negedge clk);
        sys_rst_n = 1'b1;
        step();

        // Single symbol
        wr(1'b1, 8'd5);
        chk("s1_count", 32'(fifo_count), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s1_load_busy", 32'(busy), 32'd1);
        chk("s1_load_trig", 32'(tim_trig), 32'd0);
        chk("s1_load_tx", 32'(tx_out), 32'd0);
        step();
        chk("s1_arm_trig", 32'(tim_trig), 32'd1);
        chk("s1_arm_dur", 32'(tim_duration), 32'd5);
        chk("s1_arm_tx", 32'(tx_out), 32'd1);
        chk("s1_arm_count", 32'(fifo_count), 32'd0);
        step();
        chk("s1_wait_trig", 32'(tim_trig), 32'd0);
        chk("s1_wait_tx", 32'(tx_out), 32'd1);
        step(); step(); step();
        chk("s1_wait_trig_late", 32'(tim_trig), 32'd0);
        chk("s1_wait_dur_held", 32'(tim_duration), 32'd5);
        chk("s1_wait_busy", 32'(busy), 32'd1);
        tim_done = 1'b1;
        step();
        tim_done = 1'b0;
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_tx_idle", 32'(tx_out), 32'd0);
        chk("s1_busy_fall", 32'(busy), 32'd0);
        step();
        chk("s1_done_once", 32'(done), 32'd0);

        // Three symbols
        wr(1'b1, 8'd3);
        wr(1'b0, 8'd4);
        wr(1'b1, 8'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        do_symbol("t3a", 1'b1, 8'd3);
        chk("t3_gap_tx_hold", 32'(tx_out), 32'd1);
        chk("t3_gap_done", 32'(done), 32'd0);
        do_symbol("t3b", 1'b0, 8'd4);
        do_symbol("t3c", 1'b1, 8'd2);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_tx_idle", 32'(tx_out), 32'd0);
        step();
        chk("t3_done_once", 32'(done), 32'd0);

        // Full FIFO and pointer wrap
        for (int i = 0; i < 8; i++) wr(1'(i), 8'(10 + i));
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        wr(1'b1, 8'd99);
        chk("full_ninth_dropped", 32'(fifo_count), 32'd8);
        start = 1'b1;
        step();
        start = 1'b0;
        do_symbol("w0", 1'b0, 8'd10);
        do_symbol("w1", 1'b1, 8'd11);
        step();
        chk("w2_arm_dur", 32'(tim_duration), 32'd12);
        chk("w2_arm_tx", 32'(tx_out), 32'd0);
        step();
        chk("w2_count", 32'(fifo_count), 32'd5);
        wr(1'b1, 8'd20);
        wr(1'b0, 8'd21);
        wr(1'b1, 8'd22);
        chk("wrap_count", 32'(fifo_count), 32'd8);
        chk("wrap_wr_ready", 32'(wr_ready), 32'd0);
        chk("wrap_still_wait", 32'(busy), 32'd1);
        tim_done = 1'b1;
        step();
        tim_done = 1'b0;
        for (int i = 3; i < 8; i++) do_symbol($sformatf("w%0d", i), 1'(i), 8'(10 + i));
        do_symbol("w8", 1'b1, 8'd20);
        do_symbol("w9", 1'b0, 8'd21);
        do_symbol("w10", 1'b1, 8'd22);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_empty", 32'(fifo_count), 32'd0);

        // Zero-duration skip
        wr(1'b1, 8'd0);
        wr(1'b0, 8'd7);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("z_load1_trig", 32'(tim_trig), 32'd0);
        step();
        chk("z_load2_trig", 32'(tim_trig), 32'd0);
        chk("z_load2_busy", 32'(busy), 32'd1);
        step();
        chk("z_arm_trig", 32'(tim_trig), 32'd1);
        chk("z_arm_dur", 32'(tim_duration), 32'd7);
        chk("z_arm_tx", 32'(tx_out), 32'd0);
        step();
        tim_done = 1'b1;
        step();
        tim_done = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        wr(1'b1, 8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("z_only_done", 32'(done), 32'd1);
        chk("z_only_trig", 32'(tim_trig), 32'd0);
        chk("z_only_busy", 32'(busy), 32'd0);
        chk("z_only_count", 32'(fifo_count), 32'd0);

        // Abort in WAIT with a simultaneous write
        for (int i = 0; i < 5; i++) wr(1'b1, 8'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("ab_pre_count", 32'(fifo_count), 32'd4);
        chk("ab_pre_busy", 32'(busy), 32'd1);
        abort       = 1'b1;
        wr_valid    = 1'b1;
        wr_duration = 8'd33;
        #1;
        chk("ab_wr_ready", 32'(wr_ready), 32'd0);
        step();
        abort    = 1'b0;
        wr_valid = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_count", 32'(fifo_count), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_trig", 32'(tim_trig), 32'd0);
        tim_done = 1'b1;
        step();
        tim_done = 1'b0;
        chk("ab_late_done", 32'(done), 32'd0);
        chk("ab_late_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_start_busy", 32'(busy), 32'd0);
        step();
        chk("empty_start_done", 32'(done), 32'd0);

        // Async reset mid-WAIT
        idle_level = 1'b1;
        wr(1'b0, 8'd9);
        wr(1'b0, 8'd6);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ar_arm_tx", 32'(tx_out), 32'd0);
        step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_trig", 32'(tim_trig), 32'd0);
        chk("ar_dur", 32'(tim_duration), 32'd0);
        chk("ar_count", 32'(fifo_count), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_wr_ready", 32'(wr_ready), 32'd1);
        chk("ar_tx", 32'(tx_out), 32'd1);
        @(negedge clk);
        sys_rst_n = 1'b1;
        step();
        wr(1'b0, 8'd4);
        chk("ar_post_count", 32'(fifo_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
